// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Front end for a 256x8 synchronous SRAM with a one-cycle registered read.
// Takes single load/store requests over a valid/ready handshake and returns
// load data over a valid/ready response channel. After reset it can sweep
// every SRAM location to CLEAR_VALUE before it accepts any request.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   req_valid  request present (held stable until accepted)
//   req_ready  request accepted on this edge if req_valid; high only in IDLE
//   req_we     1 = store, 0 = load
//   req_addr   target address
//   req_wdata  store data
//   rsp_valid  load data available
//   rsp_ready  consumer takes the response
//   rsp_rdata  load data (kept after the handshake; qualified by rsp_valid)
//   busy       high while the clear sweep runs
//   mem_we     SRAM write enable
//   mem_addr   SRAM address
//   mem_wdata  SRAM write data
//   mem_rdata  SRAM read data
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    CLEAR    = 3'd0,
    IDLE     = 3'd1,
    WRITE    = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DATA  = 3'd4,
    RD_WAIT  = 3'd5,
    RESP     = 3'd6
  } state_t;

  state_t     state;
  logic [7:0] clr_cnt;
  // Set on the edge that registers address 255; the sweep then ends on the
  // following edge instead of letting the 8-bit counter run past 255.
  logic       clr_done;

  assign req_ready = (state == IDLE);

  // NOTE: every register here is assigned with <= so all state updates see
  // the values from before the edge, matching the flip-flop behaviour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_cnt   <= 8'h00;
      clr_done  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      busy      <= CLEAR_ON_RESET;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_done) begin
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
            state    <= IDLE;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= clr_cnt;
            mem_wdata <= CLEAR_VALUE;
            clr_cnt   <= clr_cnt + 8'd1;
            if (clr_cnt == 8'hFF) clr_done <= 1'b1;
          end
        end

        IDLE: begin
          if (req_valid) begin
            mem_addr <= req_addr;
            if (req_we) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              mem_we <= 1'b0;
              state  <= RD_ISSUE;
            end
          end else begin
            mem_we <= 1'b0;
          end
        end

        // SRAM samples the write on this edge; one store per two cycles.
        WRITE: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end

        // SRAM registers the read address on this edge.
        RD_ISSUE: state <= RD_DATA;

        // SRAM output has settled; one more edge gives the three-edge load
        // latency from accept to rsp_valid.
        RD_DATA: state <= RD_WAIT;

        RD_WAIT: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        // NOTE: the spare encoding recovers to IDLE with the write strobe
        // forced low, so a corrupted state can never write the SRAM.
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Three instances share clk, rst and rsp_ready:
//   0: CLEAR_ON_RESET=1, CLEAR_VALUE=8'h00
//   1: CLEAR_ON_RESET=1, CLEAR_VALUE=8'hA5
//   2: CLEAR_ON_RESET=0
// Each drives its own behavioural 256x8 SRAM with a one-cycle registered read.
// Load expectations go into a scoreboard queue at accept time and are popped
// when the response handshake is seen.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rsp_ready;

  logic       req_valid [3];
  logic       req_we    [3];
  logic [7:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       req_ready [3];
  logic       rsp_valid [3];
  logic [7:0] rsp_rdata [3];
  logic       busy      [3];
  logic       mem_we    [3];
  logic [7:0] mem_addr  [3];
  logic [7:0] mem_wdata [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] sram [256];
    logic [7:0] rdata;

    always @(posedge clk) begin
      if (mem_we[g]) sram[mem_addr[g]] <= mem_wdata[g];
      rdata <= sram[mem_addr[g]];
    end

    mem_access_ctrl #(
      .CLEAR_ON_RESET(g != 2),
      .CLEAR_VALUE   ((g == 1) ? 8'hA5 : 8'h00)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata[g]),
      .busy     (busy[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(rdata)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb [$];

  // Response monitor: compare on the cycle whose next edge completes the
  // handshake, so each response is consumed exactly once.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i] === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: dut %0d got rdata %h with no load pending", i, rsp_rdata[i]);
        end else begin
          sb_item_t it;
          it = sb.pop_front();
          check_n("rsp_dut_idx", i, it.idx);
          check("rsp_rdata", rsp_rdata[i], it.exp);
        end
      end
    end
  end

  // One request: wait (bounded) for req_ready, accept, then check the
  // store strobe or the load latency. Returns at the negedge after the
  // edge that retires the store, or after the third post-accept edge.
  task automatic do_op(input int i, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp);
    bit ok;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (req_ready[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check_b("req_ready_timeout", 1'b0, 1'b1);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    if (!we) sb.push_back('{i, exp});
    @(negedge clk);
    if (we) begin
      check_b("st_we_pulse", mem_we[i], 1'b1);
      check("st_addr", mem_addr[i], addr);
      check("st_wdata", mem_wdata[i], wdata);
      check_b("st_ready_low", req_ready[i], 1'b0);
      @(negedge clk);
      check_b("st_we_drop", mem_we[i], 1'b0);
    end else begin
      check_b("ld_we_low", mem_we[i], 1'b0);
      check("ld_addr", mem_addr[i], addr);
      check_b("ld_valid_e1", rsp_valid[i], 1'b0);
      @(negedge clk);
      check_b("ld_valid_e2", rsp_valid[i], 1'b0);
      @(negedge clk);
      check_b("ld_valid_e3", rsp_valid[i], 1'b0);
      @(negedge clk);
      check_b("ld_valid_rise", rsp_valid[i], 1'b1);
    end
  endtask

  // Called right after rst is released (posedge + 1). Verifies both
  // clearing instances write 0x00..0xFF on 256 consecutive cycles, then idle.
  task automatic check_sweep();
    int bad_a = 0;
    int bad_b = 0;
    @(negedge clk);
    check_b("sweep_pre_busy", busy[0], 1'b1);
    check_b("sweep_pre_we", mem_we[0], 1'b0);
    check_b("cor0_ready_first_cycle", req_ready[2], 1'b1);
    check_b("cor0_busy", busy[2], 1'b0);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (mem_we[0] !== 1'b1 || mem_addr[0] !== k[7:0] || mem_wdata[0] !== 8'h00 ||
          busy[0] !== 1'b1 || req_ready[0] !== 1'b0) bad_a++;
      if (mem_we[1] !== 1'b1 || mem_addr[1] !== k[7:0] || mem_wdata[1] !== 8'hA5 ||
          busy[1] !== 1'b1 || req_ready[1] !== 1'b0) bad_b++;
    end
    check_n("sweep_a_bad_cycles", bad_a, 0);
    check_n("sweep_b_bad_cycles", bad_b, 0);
    @(negedge clk);
    check_b("sweep_end_we", mem_we[0], 1'b0);
    check_b("sweep_end_busy", busy[0], 1'b0);
    check_b("sweep_end_ready", req_ready[0], 1'b1);
    check_b("sweep_end_we_b", mem_we[1], 1'b0);
    check_b("sweep_end_busy_b", busy[1], 1'b0);
  endtask

  typedef struct {
    int         idx;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 1'b1, 8'h10, 8'h3C, 8'h00};
    vecs[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[2]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[3]  = '{0, 1'b1, 8'hFF, 8'h5A, 8'h00};
    vecs[4]  = '{0, 1'b0, 8'hFF, 8'h00, 8'h5A};
    vecs[5]  = '{0, 1'b0, 8'h80, 8'h00, 8'h00};
    vecs[6]  = '{0, 1'b1, 8'h10, 8'hC3, 8'h00};
    vecs[7]  = '{0, 1'b0, 8'h10, 8'h00, 8'hC3};
    vecs[8]  = '{1, 1'b0, 8'hFF, 8'h00, 8'hA5};
    vecs[9]  = '{1, 1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[10] = '{2, 1'b1, 8'h00, 8'h11, 8'h00};
    vecs[11] = '{2, 1'b1, 8'h01, 8'h22, 8'h00};
    vecs[12] = '{2, 1'b0, 8'h00, 8'h00, 8'h11};
    vecs[13] = '{2, 1'b0, 8'h01, 8'h00, 8'h22};

    rst       = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 8'h00;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_b("rst_busy_a", busy[0], 1'b1);
    check_b("rst_busy_c", busy[2], 1'b0);
    check_b("rst_we", mem_we[0], 1'b0);
    check("rst_addr", mem_addr[0], 8'h00);
    check_b("rst_rsp_valid", rsp_valid[0], 1'b0);
    check_b("rst_ready_a", req_ready[0], 1'b0);
    check_b("rst_ready_c", req_ready[2], 1'b1);
    rst = 1'b1;
    check_sweep();

    // Table of single requests across the three instances.
    for (int v = 0; v < 14; v++)
      do_op(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp);

    // Response stall: rsp_ready low for 5 cycles with valid up.
    @(negedge clk);
    rsp_ready = 1'b0;
    do_op(0, 1'b0, 8'h10, 8'h00, 8'hC3);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      check_b("stall_valid", rsp_valid[0], 1'b1);
      check("stall_rdata", rsp_rdata[0], 8'hC3);
      check_b("stall_ready", req_ready[0], 1'b0);
      check_b("stall_we", mem_we[0], 1'b0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_b("stall_done_ready", req_ready[0], 1'b1);
    check_b("stall_done_valid", rsp_valid[0], 1'b0);
    check("stall_done_rdata_kept", rsp_rdata[0], 8'hC3);

    // Reset while a load sits in RD_WAIT.
    check_b("rdwait_pre_ready", req_ready[0], 1'b1);
    req_we[0]    = 1'b0;
    req_addr[0]  = 8'h10;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_b("rdwait_ready_low", req_ready[0], 1'b0);
    begin
      int rose = 0;
      repeat (4) begin
        @(negedge clk);
        if (rsp_valid[0] !== 1'b0) rose++;
      end
      check_n("rdwait_valid_never_rises", rose, 0);
    end
    check_b("rdwait_rst_busy", busy[0], 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    check_sweep();

    // Reset mid-sweep at address 0x80.
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    repeat (8'h81) @(negedge clk);
    check("midsweep_addr", mem_addr[0], 8'h80);
    rst = 1'b0;
    @(negedge clk);
    check_b("midsweep_rst_we", mem_we[0], 1'b0);
    check("midsweep_rst_addr", mem_addr[0], 8'h00);
    check_b("midsweep_rst_busy", busy[0], 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    check_sweep();

    // Memory cleared again after the restarted sweep.
    do_op(0, 1'b0, 8'h10, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_n("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
